// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage
//   Load/store unit sitting after the core's execute stage. A load or store
//   is latched in IDLE, issued on a valid/ready data-memory bus, and its
//   result is presented on busw in DONE. Non-memory instructions pass
//   alu_result straight through to busw. Stall is asserted while an access
//   is in flight so the core holds its PC and instruction registers.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   alu_result           effective address / non-memory write-back value
//   wdata                store data (rs2)
//   memop                funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   memwr, memtoreg      store / load instruction (both set = store)
//   busw                 register write-back data
//   stall                core must hold state this cycle
//   misalign_err         one-cycle pulse on a misaligned access
//   mem_req_valid/ready  request handshake
//   mem_addr             word-aligned address
//   mem_wen              1 = write
//   mem_wdata            store data shifted to its byte lane
//   mem_wstrb            byte enables
//   mem_rsp_valid        read data / write ack valid
//   mem_rdata            full read word
module lsu_mem_stage #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] alu_result,
  input  logic [DW-1:0] wdata,
  input  logic [2:0]    memop,
  input  logic          memwr,
  input  logic          memtoreg,
  output logic [DW-1:0] busw,
  output logic          stall,
  output logic          misalign_err,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wen,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_wstrb,
  input  logic          mem_rsp_valid,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10,
    S_DONE = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [2:0]    memop_q, memop_d;
  logic          wr_q, wr_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          op_s;
  logic          misalign_s;

  // Select and sign/zero-extend the addressed byte/half from a full read word.
  function automatic logic [31:0] load_extract(input logic [2:0] op,
                                               input logic [1:0] a,
                                               input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rd[{a, 3'b000} +: 8];
    h = a[1] ? rd[31:16] : rd[15:0];
    case (op[1:0])
      2'b00:   r = op[2] ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   r = op[2] ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  // Byte enables for a store of the given size at byte offset a.
  function automatic logic [3:0] store_strb(input logic [2:0] op,
                                            input logic [1:0] a);
    logic [3:0] s;
    case (op[1:0])
      2'b00:   s = 4'b0001 << a;
      2'b01:   s = 4'b0011 << a;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  // Decode the incoming instruction: memory op present and alignment check.
  always_comb begin
    op_s       = memwr | memtoreg;
    misalign_s = 1'b0;
    case (memop[1:0])
      2'b00:   misalign_s = 1'b0;
      2'b01:   misalign_s = alu_result[0];
      default: misalign_s = (alu_result[1:0] != 2'b00);
    endcase
  end

  // Next-state, latch updates, stall and write-back data.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    memop_d      = memop_q;
    wr_d         = wr_q;
    rdata_d      = rdata_q;
    stall        = 1'b0;
    misalign_err = 1'b0;
    busw         = {DW{1'b0}};
    case (state_q)
      S_IDLE: begin
        if (op_s) begin
          if (misalign_s) begin
            // No bus transaction; loads write back zero.
            misalign_err = 1'b1;
            state_d      = S_IDLE;
          end else begin
            addr_d  = alu_result;
            wdata_d = wdata;
            memop_d = memop;
            wr_d    = memwr;
            stall   = 1'b1;
            state_d = S_REQ;
          end
        end else begin
          busw    = alu_result;
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        stall = 1'b1;
        if (mem_req_ready) begin
          if (mem_rsp_valid) begin
            rdata_d = load_extract(memop_q, addr_q[1:0], mem_rdata);
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (mem_rsp_valid) begin
          rdata_d = load_extract(memop_q, addr_q[1:0], mem_rdata);
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        // Core inputs are not trusted here; the latched address stands in
        // for alu_result on stores.
        busw    = wr_q ? addr_q : rdata_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Bus outputs come only from registered state, so they are stable in REQ.
  always_comb begin
    mem_req_valid = (state_q == S_REQ);
    mem_addr      = {addr_q[AW-1:2], 2'b00};
    mem_wen       = (state_q == S_REQ) & wr_q;
    mem_wdata     = wdata_q << {addr_q[1:0], 3'b000};
    if ((state_q == S_REQ) && wr_q) begin
      mem_wstrb = store_strb(memop_q, addr_q[1:0]);
    end else begin
      mem_wstrb = 4'b0000;
    end
  end

  // State and latched-operand registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= {AW{1'b0}};
      wdata_q <= {DW{1'b0}};
      memop_q <= 3'b000;
      wr_q    <= 1'b0;
      rdata_q <= {DW{1'b0}};
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      memop_q <= memop_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage
//   Table-driven bench for lsu_mem_stage: each record carries the core-side
//   inputs, the bus response, and the expected bus request and write-back
//   value. Write-back expectations are queued when an access is issued and
//   popped when the unit reaches DONE. Hand-written sequences cover reset
//   behaviour and reset during an outstanding access.
module tb_lsu_mem_stage;

  logic        clk;
  logic        rst;
  logic [31:0] alu_result;
  logic [31:0] wdata;
  logic [2:0]  memop;
  logic        memwr;
  logic        memtoreg;
  logic [31:0] busw;
  logic        stall;
  logic        misalign_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        memwr;
    logic        memtoreg;
    logic [2:0]  memop;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] exp_busw;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    logic        exp_mis;
    int          rdy_dly;
    logic        rsp_same;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb[$];

  lsu_mem_stage #(.AW(32), .DW(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .alu_result    (alu_result),
    .wdata         (wdata),
    .memop         (memop),
    .memwr         (memwr),
    .memtoreg      (memtoreg),
    .busw          (busw),
    .stall         (stall),
    .misalign_err  (misalign_err),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_req(input vec_t v);
    check("req_valid", {31'd0, mem_req_valid}, 32'd1);
    check("req_addr", mem_addr, v.addr & 32'hFFFF_FFFC);
    check("req_wen", {31'd0, mem_wen}, {31'd0, v.memwr});
    if (v.memwr) begin
      check("req_wdata", mem_wdata, v.exp_wdata);
      check("req_wstrb", {28'd0, mem_wstrb}, {28'd0, v.exp_wstrb});
    end
    check("req_stall", {31'd0, stall}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] exp_b;
    int          stalls;
    stalls        = 0;
    alu_result    = v.addr;
    wdata         = v.wdata;
    memop         = v.memop;
    memwr         = v.memwr;
    memtoreg      = v.memtoreg;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rdata     = 32'h0;
    @(negedge clk);
    if (!(v.memwr | v.memtoreg)) begin
      check("pass_busw", busw, v.exp_busw);
      check("pass_stall", {31'd0, stall}, 32'd0);
      check("pass_valid", {31'd0, mem_req_valid}, 32'd0);
      @(posedge clk); #1;
    end else if (v.exp_mis) begin
      check("mis_err", {31'd0, misalign_err}, 32'd1);
      check("mis_stall", {31'd0, stall}, 32'd0);
      check("mis_valid", {31'd0, mem_req_valid}, 32'd0);
      if (!v.memwr) check("mis_busw", busw, 32'd0);
      @(posedge clk); #1;
      memwr    = 1'b0;
      memtoreg = 1'b0;
      @(negedge clk);
      check("mis_after_valid", {31'd0, mem_req_valid}, 32'd0);
      check("mis_pulse_end", {31'd0, misalign_err}, 32'd0);
      @(posedge clk); #1;
    end else begin
      check("idle_mis", {31'd0, misalign_err}, 32'd0);
      check("idle_valid", {31'd0, mem_req_valid}, 32'd0);
      stalls += int'(stall);
      sb.push_back(v.exp_busw);
      @(posedge clk); #1;
      // Core inputs are don't-care once the access is latched.
      alu_result = $urandom;
      wdata      = $urandom;
      memop      = 3'($urandom_range(0, 7));
      memwr      = 1'($urandom_range(0, 1));
      memtoreg   = 1'($urandom_range(0, 1));
      mem_rdata  = $urandom;
      for (int d = 0; d < v.rdy_dly; d++) begin
        @(negedge clk);
        check_req(v);
        stalls += int'(stall);
        @(posedge clk); #1;
      end
      mem_req_ready = 1'b1;
      if (v.rsp_same) begin
        mem_rsp_valid = 1'b1;
        mem_rdata     = v.rdata;
      end
      @(negedge clk);
      check_req(v);
      stalls += int'(stall);
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      if (!v.rsp_same) begin
        mem_rsp_valid = 1'b1;
        mem_rdata     = v.rdata;
        @(negedge clk);
        check("wait_valid", {31'd0, mem_req_valid}, 32'd0);
        stalls += int'(stall);
        @(posedge clk); #1;
      end
      mem_rsp_valid = 1'b0;
      mem_rdata     = $urandom;
      @(negedge clk);
      check("done_stall", {31'd0, stall}, 32'd0);
      exp_b = 32'hxxxx_xxxx;
      if (sb.size() > 0) exp_b = sb.pop_front();
      check("done_busw", busw, exp_b);
      check("stall_cycles", stalls, v.rdy_dly + (v.rsp_same ? 2 : 3));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    //           wr    ld    op      addr          wdata         rdata         busw          wdata_exp     strb     mis   dly rsp_same
    vecs.push_back('{1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0,        32'h0,        32'h1234_5678, 32'h0,        4'b0000, 1'b0, 0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 3'b010, 32'h8000_0010, 32'h0,        32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0,        4'b0000, 1'b0, 0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 3'b000, 32'h8000_0013, 32'h0,        32'h80FF_7F01, 32'hFFFF_FF80, 32'h0,        4'b0000, 1'b0, 0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 3'b100, 32'h8000_0013, 32'h0,        32'h80FF_7F01, 32'h0000_0080, 32'h0,        4'b0000, 1'b0, 0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 3'b001, 32'h8000_0012, 32'h0,        32'h80FF_7F01, 32'hFFFF_80FF, 32'h0,        4'b0000, 1'b0, 0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 3'b101, 32'h8000_0012, 32'h0,        32'h80FF_7F01, 32'h0000_80FF, 32'h0,        4'b0000, 1'b0, 0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 3'b000, 32'h8000_0011, 32'h0,        32'h80FF_7F01, 32'h0000_007F, 32'h0,        4'b0000, 1'b0, 0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 3'b001, 32'h8000_0010, 32'h0,        32'h80FF_7F01, 32'h0000_7F01, 32'h0,        4'b0000, 1'b0, 0, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 3'b000, 32'h8000_0002, 32'h0000_00AB, 32'h0,        32'h8000_0002, 32'h00AB_0000, 4'b0100, 1'b0, 0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h8000_0004, 32'h1234_5678, 32'h0,        32'h8000_0004, 32'h1234_5678, 4'b1111, 1'b0, 5, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 3'b001, 32'h8000_0006, 32'h0000_BEEF, 32'h0,        32'h8000_0006, 32'hBEEF_0000, 4'b1100, 1'b0, 0, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 3'b000, 32'h8000_0003, 32'h0000_00CD, 32'h0,        32'h8000_0003, 32'hCD00_0000, 4'b1000, 1'b0, 1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 3'b010, 32'h8000_0002, 32'h0,        32'h0,        32'h0,         32'h0,        4'b0000, 1'b1, 0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 3'b001, 32'h8000_0001, 32'h0,        32'h0,        32'h0,         32'h0,        4'b0000, 1'b1, 0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h8000_0001, 32'h5555_5555, 32'h0,        32'h0,         32'h0,        4'b0000, 1'b1, 0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 3'b100, 32'h0000_0000, 32'h0,        32'h0000_00F0, 32'h0000_00F0, 32'h0,        4'b0000, 1'b0, 2, 1'b1});

    rst           = 1'b1;
    alu_result    = 32'h0;
    wdata         = 32'h0;
    memop         = 3'b000;
    memwr         = 1'b0;
    memtoreg      = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rdata     = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'd0, mem_req_valid}, 32'd0);
    check("rst_wen", {31'd0, mem_wen}, 32'd0);
    check("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
    check("rst_mis", {31'd0, misalign_err}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i]);
    end

    // Reset while waiting for a load response; the late response is dropped.
    alu_result = 32'h8000_0020;
    memop      = 3'b010;
    memwr      = 1'b0;
    memtoreg   = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b1;
    @(negedge clk);
    check("rw_req_valid", {31'd0, mem_req_valid}, 32'd1);
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    rst           = 1'b1;
    @(negedge clk);
    check("rw_wait_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    rst           = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'hCAFE_F00D;
    memtoreg      = 1'b0;
    alu_result    = 32'h1357_9BDF;
    @(negedge clk);
    check("rw_idle_valid", {31'd0, mem_req_valid}, 32'd0);
    check("rw_idle_stall", {31'd0, stall}, 32'd0);
    check("rw_idle_busw", busw, 32'h1357_9BDF);
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    alu_result    = 32'h2468_ACE0;
    @(negedge clk);
    check("rw_next_valid", {31'd0, mem_req_valid}, 32'd0);
    check("rw_next_stall", {31'd0, stall}, 32'd0);
    check("rw_next_busw", busw, 32'h2468_ACE0);
    check("sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
